data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `CLOCK` and `RESET`.
REQ-002 Parameter `DEPTH_WORDS`, default 1024: number of 32-bit words in the array.
REQ-003 Parameter `LATENCY`, default 2, legal range 0..15: number of wait cycles per access.
REQ-004 Ports, as name / direction / width / meaning:
- `CLOCK` / in / 1 / clock.
- `RESET` / in / 1 / synchronous active-high reset.
- `Address_IN` / in / 32 / byte address from the MEM stage ALU result.
- `WriteData_IN` / in / 32 / right-justified store data from MEM.
- `DataSize_IN` / in / 2 / store size: 0 = word, 1 = byte, 2 = half, 3 = three bytes.
- `MemRead_IN` / in / 1 / read request.
- `MemWrite_IN` / in / 1 / write request.
- `ReadData_OUT` / out / 32 / full aligned word returned to MEM.
- `Stall_OUT` / out / 1 / holds the pipeline while an access is pending.
- `Fault_OUT` / out / 1 / out-of-range access (only with the macro in REQ-019).

Function
REQ-005 A request SHALL be `MemRead_IN | MemWrite_IN`. If both are high, the access SHALL be treated as a write, and `ReadData_OUT` SHALL return the pre-write word.
REQ-006 The FSM SHALL have two states:
- IDLE, with wait counter = 0.
- WAIT, with the wait counter counting 1..`LATENCY`.
REQ-007 In IDLE, when a request is present and `LATENCY` > 0:
- latch address, data, size and op;
- drive `Stall_OUT` = 1;
- go to WAIT with counter = 1.
REQ-008 In WAIT with counter < `LATENCY`:
- `Stall_OUT` = 1;
- counter increments;
- inputs are ignored; the latched values govern the access.
REQ-009 The completion cycle is either WAIT with counter = `LATENCY`, or IDLE with a request and `LATENCY` = 0 (inputs used directly). In the completion cycle:
- `Stall_OUT` = 0;
- a read drives `ReadData_OUT` = array[word address] combinationally;
- a write commits at the closing clock edge;
- the next state is IDLE.
REQ-010 Every access SHALL occupy exactly `LATENCY`+1 cycles, with `Stall_OUT` high in the first `LATENCY` of them.
REQ-011 Back-to-back requests: a request presented in the cycle after completion SHALL start a new access from IDLE with no bubble.
REQ-012 `ReadData_OUT` SHALL be 0 in every cycle that is not a read completion.
REQ-013 The word index SHALL be `Address[31:2]` modulo `DEPTH_WORDS`, and the byte offset SHALL be `Address[1:0]`. The array is big-endian: byte 0 = bits [31:24], byte 3 = bits [7:0].
REQ-014 Byte-enable lanes by (size, offset):
- size 0: lanes 0-3 (any offset).
- size 1: lane = offset.
- size 2: offset 0 or 1 → lanes 0-1; offset 2 or 3 → lanes 2-3.
- size 3: offset 0 or 2 → lanes 0-2; offset 1 or 3 → lanes 1-3.
REQ-015 Write data placement: the N enabled lanes SHALL receive the low N bytes of the latched write data in order, with the most-significant enabled lane taking the most-significant of those bytes. Disabled lanes SHALL be unchanged.
REQ-016 Reads SHALL ignore size and offset and always return the full word; alignment is done downstream in MEM.

Reset
REQ-017 While `RESET` is high:
- state = IDLE, counter = 0;
- `Stall_OUT` = 0, `ReadData_OUT` = 0, `Fault_OUT` = 0;
- no write commits.
REQ-018 Reset asserted mid-access SHALL abandon the access without committing it. Array contents are not reset.

Configuration
REQ-019 With `DM_RANGE_CHECK_EN` defined, a completing access with `Address[31:2]` >= `DEPTH_WORDS` SHALL:
- pulse `Fault_OUT` for that cycle;
- suppress the write;
- return `ReadData_OUT` = 32'hDEADBEEF.
Without the macro, `Fault_OUT` SHALL be tied to 0 and addresses SHALL wrap per REQ-013.

Structure
REQ-020 Shared package `dm_pkg` SHALL hold:
- the DataSize encodings (`DS_WORD`, `DS_BYTE`, `DS_HALF`, `DS_TRIPLE`);
- the FSM state type;
- the fault pattern constant.
REQ-021 Combinational sub-module `dm_lane_decode` SHALL map (size, offset) to a 4-bit enable plus placed 32-bit write data, per REQ-014 and REQ-015.

Verification
REQ-022 The bench SHALL cover these directed scenarios (`LATENCY` = 2 unless stated):
- **Word write/read:** SW 32'h11223344 to address 0x10, then read 0x10. Required: `Stall_OUT` is 1,1,0 for each access; the read returns 32'h11223344.
- **Byte store:** pre-fill word 0x10 with 32'hAABBCCDD, SB 8'h5A to address 0x12. Required: word = 32'hAABB5ADD.
- **Half/triple stores:** SH 16'h1234 to 0x11 gives 32'h1234CCDD. Size 3 with data 24'h778899 to 0x11 on the original word gives 32'hAA778899.
- **Reset mid-access:** assert `RESET` in the 2nd stall cycle of a write. Required: word unchanged, `Stall_OUT` = 0 the next cycle, the next access completes normally.
- **Zero latency:** `LATENCY` = 0, back-to-back reads of two addresses. Required: `Stall_OUT` never high; correct data each cycle.
- **Range check:** with `DM_RANGE_CHECK_EN` and `DEPTH_WORDS` = 16, write to 0x40. Required: `Fault_OUT` = 1 in the completion cycle and word 0 unchanged. Without the macro, the same write lands in word 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the data memory controller: store-size
// encodings, FSM state type, latched access record and the fault read pattern.
package dm_pkg;

    localparam logic [1:0] DS_WORD   = 2'd0;
    localparam logic [1:0] DS_BYTE   = 2'd1;
    localparam logic [1:0] DS_HALF   = 2'd2;
    localparam logic [1:0] DS_TRIPLE = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } dm_state_t;

    localparam logic [31:0] DM_FAULT_PATTERN = 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        rd;
        logic        wr;
    } dm_req_t;

endpackage

// File: rtl/dm_lane_decode.sv
// Maps (store size, byte offset) to big-endian byte-lane enables and places the
// right-justified store data so the last enabled lane receives the lowest byte.
module dm_lane_decode
    import dm_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata_placed
);

    logic [1:0]  w_first;
    logic [1:0]  w_last;
    logic [31:0] w_shifted;

    always_comb begin
        w_first = 2'd0;
        w_last  = 2'd3;
        case (i_size)
            DS_BYTE: begin
                w_first = i_offset;
                w_last  = i_offset;
            end
            DS_HALF: begin
                w_first = {i_offset[1], 1'b0};
                w_last  = {i_offset[1], 1'b1};
            end
            DS_TRIPLE: begin
                w_first = {1'b0, i_offset[0]};
                w_last  = i_offset[0] ? 2'd3 : 2'd2;
            end
            default: begin
                w_first = 2'd0;
                w_last  = 2'd3;
            end
        endcase
    end

    // Lane 3 holds bits [7:0], so shifting by the gap after the last lane
    // lines the low data bytes up with the enabled lanes.
    assign w_shifted = i_wdata << {(2'd3 - w_last), 3'b000};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign o_byte_en[gi] = (2'(gi) >= w_first) && (2'(gi) <= w_last);
            assign o_wdata_placed[31-8*gi -: 8] = o_byte_en[gi] ? w_shifted[31-8*gi -: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller with a fixed wait-state count per access.
// Optional macro DM_RANGE_CHECK_EN flags out-of-range accesses instead of wrapping.
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] Address_IN,
    input  logic [31:0] WriteData_IN,
    input  logic [1:0]  DataSize_IN,
    input  logic        MemRead_IN,
    input  logic        MemWrite_IN,
    output logic [31:0] ReadData_OUT,
    output logic        Stall_OUT,
    output logic        Fault_OUT
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT     = 4'(LATENCY);
    localparam logic [29:0] DEPTH30 = 30'(DEPTH_WORDS);

    logic [31:0] r_mem [DEPTH_WORDS];

    dm_state_t   r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    dm_req_t     r_req;
    dm_req_t     w_req_in;
    dm_req_t     w_acc;
    logic        w_req_valid;
    logic        w_complete;
    logic        w_stall;
    logic        w_oor;
    logic        w_we;
    logic [29:0] w_word;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_be;
    logic [31:0] w_wplaced;
    logic [31:0] w_rword;

    assign w_req_in    = '{addr: Address_IN, wdata: WriteData_IN, size: DataSize_IN,
                           rd: MemRead_IN, wr: MemWrite_IN};
    assign w_req_valid = MemRead_IN | MemWrite_IN;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        w_complete   = 1'b0;
        w_acc        = w_req_in;
        case (r_state)
            ST_IDLE: begin
                if (w_req_valid) begin
                    if (LAT == 4'd0) begin
                        w_complete = 1'b1;
                    end else begin
                        w_stall      = 1'b1;
                        w_state_next = ST_WAIT;
                        w_cnt_next   = 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                w_acc = r_req;
                if (r_cnt != LAT) begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt + 4'd1;
                end else begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 4'd0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
        // Reset masks the outputs in the same cycle and abandons any access.
        if (RESET) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = 4'd0;
            w_stall      = 1'b0;
            w_complete   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
        // Capturing every idle cycle is harmless: only the one that starts WAIT matters.
        if (r_state == ST_IDLE) begin
            r_req <= w_req_in;
        end
    end

    assign w_word = w_acc.addr[31:2];
    assign w_idx  = AW'(w_word % DEPTH30);

`ifdef DM_RANGE_CHECK_EN
    assign w_oor = (w_word >= DEPTH30);
`else
    assign w_oor = 1'b0;
`endif

    dm_lane_decode u_lane_decode (
        .i_size         (w_acc.size),
        .i_offset       (w_acc.addr[1:0]),
        .i_wdata        (w_acc.wdata),
        .o_byte_en      (w_be),
        .o_wdata_placed (w_wplaced)
    );

    assign w_rword = r_mem[w_idx];
    assign w_we    = w_complete & w_acc.wr & ~w_oor;

    always_ff @(posedge CLOCK) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][31-8*i -: 8] <= w_wplaced[31-8*i -: 8];
                end
            end
        end
    end

    always_comb begin
        ReadData_OUT = 32'h0;
        if (w_complete) begin
            if (w_oor) begin
                ReadData_OUT = DM_FAULT_PATTERN;
            end else if (w_acc.rd) begin
                ReadData_OUT = w_rword;
            end
        end
    end

    assign Stall_OUT = w_stall;
    assign Fault_OUT = w_complete & w_oor;

endmodule
